rq_tlp_scheduler: RTL and testbench



---
 rtl/rq_tlp_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_rq_tlp_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rq_tlp_scheduler.sv
// Round-robin requester-to-TLP-encoder scheduler with a non-posted tag pool
// and a watchdog on encoder completion.
module rq_tlp_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_TAGS    = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  user_clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [3*NUM_REQ-1:0]  req_type,
    input  logic [64*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  req_err,
    output logic [7:0]            req_tag,
    output logic [2:0]            tx_type,
    output logic [7:0]            tx_tag,
    output logic [63:0]           tx_addr,
    output logic [31:0]           tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    input  logic                  cpl_valid,
    input  logic [7:0]            cpl_tag,
    output logic [8:0]            tags_free,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int GW  = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t               r_state, w_state_nxt;
    logic [GW-1:0]        r_last_grant;
    logic [NUM_REQ-1:0]   r_grant_oh;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_err;
    logic [7:0]           r_req_tag;
    logic [2:0]           r_tx_type;
    logic [7:0]           r_tx_tag;
    logic [63:0]          r_tx_addr;
    logic [31:0]          r_tx_data;
    logic                 r_np;
    logic [WDW-1:0]       r_wd;
    logic                 r_timeout;
    logic [NUM_TAGS-1:0]  r_alloc;
    logic [8:0]           r_tags_free;

    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_grant_vld;
    logic [GW-1:0]        w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic                 w_can_grant;
    logic [2:0]           w_win_type;
    logic [63:0]          w_win_addr;
    logic [31:0]          w_win_data;
    logic                 w_win_posted;
    logic                 w_win_illegal;
    logic                 w_alloc_now;
    logic [7:0]           w_free_idx;
    logic [NUM_TAGS-1:0]  w_alloc_nxt;
    logic [8:0]           w_used_cnt;
    logic                 w_timeout;

    function automatic logic f_posted(input logic [2:0] t);
        return (t == 3'd1) || (t == 3'd3);
    endfunction

    function automatic logic f_illegal(input logic [2:0] t);
        return t[2:1] == 2'b11;
    endfunction

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_elig[i] = req_valid[i] && (f_posted(req_type[3*i +: 3]) ||
                        f_illegal(req_type[3*i +: 3]) || (r_tags_free != 9'd0));
    end

    // Rotating search starting one past the previous winner.
    always_comb begin
        logic [GW-1:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        v_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_grant_vld && w_elig[v_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_idx;
            end
        end
    end

    always_comb begin
        w_win_type = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == GW'(i)) begin
                w_win_type = req_type[3*i +: 3];
                w_win_addr = req_addr[64*i +: 64];
                w_win_data = req_data[32*i +: 32];
            end
        end
    end

    assign w_grant_oh    = NUM_REQ'(1) << w_grant_idx;
    assign w_win_posted  = f_posted(w_win_type);
    assign w_win_illegal = f_illegal(w_win_type);
    // The acknowledge cycle is a dead cycle so the acked requester can drop valid.
    assign w_can_grant   = (r_state == S_IDLE) && (r_ack == '0) && w_grant_vld;
    assign w_alloc_now   = w_can_grant && !w_win_illegal && !w_win_posted;
    assign w_timeout     = (r_state == S_WAIT) && !tx_done && (r_wd == WDW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_free_idx = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--)
            if (!r_alloc[t]) w_free_idx = 8'(t);
    end

    // Frees act on the current pool, so a tag freed now is allocatable next cycle.
    always_comb begin
        w_alloc_nxt = r_alloc;
        w_used_cnt  = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (cpl_valid && cpl_tag == 8'(t))               w_alloc_nxt[t] = 1'b0;
            if (w_timeout && r_np && r_tx_tag == 8'(t))      w_alloc_nxt[t] = 1'b0;
            if (w_alloc_now && w_free_idx == 8'(t))          w_alloc_nxt[t] = 1'b1;
            w_used_cnt = w_used_cnt + 9'(w_alloc_nxt[t]);
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_can_grant && !w_win_illegal) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (tx_done || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_start = (r_state == S_START);
        busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant_oh   <= '0;
            r_ack        <= '0;
            r_err        <= 1'b0;
            r_req_tag    <= '0;
            r_tx_type    <= '0;
            r_tx_tag     <= '0;
            r_tx_addr    <= '0;
            r_tx_data    <= '0;
            r_np         <= 1'b0;
            r_wd         <= '0;
            r_timeout    <= 1'b0;
            r_alloc      <= '0;
            r_tags_free  <= 9'(NUM_TAGS);
        end else begin
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_alloc     <= w_alloc_nxt;
            r_tags_free <= 9'(NUM_TAGS) - w_used_cnt;
            if (w_can_grant) begin
                r_last_grant <= w_grant_idx;
                r_grant_oh   <= w_grant_oh;
                if (w_win_illegal) begin
                    r_ack     <= w_grant_oh;
                    r_err     <= 1'b1;
                    r_req_tag <= '0;
                end else begin
                    r_tx_type <= w_win_type;
                    r_tx_addr <= w_win_addr;
                    r_tx_data <= w_win_data;
                    r_tx_tag  <= w_win_posted ? 8'h00 : w_free_idx;
                    r_np      <= !w_win_posted;
                end
            end
            if (r_state == S_START)     r_wd <= '0;
            else if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
            if (r_state == S_WAIT && (tx_done || w_timeout)) begin
                r_ack     <= r_grant_oh;
                r_err     <= w_timeout;
                r_req_tag <= r_tx_tag;
                if (w_timeout) r_timeout <= 1'b1;
            end
        end
    end

    assign req_ack     = r_ack;
    assign req_err     = r_err;
    assign req_tag     = r_req_tag;
    assign tx_type     = r_tx_type;
    assign tx_tag      = r_tx_tag;
    assign tx_addr     = r_tx_addr;
    assign tx_data     = r_tx_data;
    assign tags_free   = r_tags_free;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_rq_tlp_scheduler.sv
// Bench for rq_tlp_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin / tag-pool model.
module tb_rq_tlp_scheduler;
    localparam int NR = 4;
    localparam int NT = 32;
    localparam int TO = 16;

    logic            user_clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid;
    logic [3*NR-1:0] req_type;
    logic [64*NR-1:0] req_addr;
    logic [32*NR-1:0] req_data;
    logic [NR-1:0]   req_ack;
    logic            req_err;
    logic [7:0]      req_tag;
    logic [2:0]      tx_type;
    logic [7:0]      tx_tag;
    logic [63:0]     tx_addr;
    logic [31:0]     tx_data;
    logic            tx_start;
    logic            tx_done = 1'b0;
    logic            cpl_valid = 1'b0;
    logic [7:0]      cpl_tag = 8'h00;
    logic [8:0]      tags_free;
    logic            busy;
    logic            timeout_err;

    rq_tlp_scheduler #(.NUM_REQ(NR), .NUM_TAGS(NT), .TIMEOUT_CYC(TO)) dut (
        .user_clk(user_clk), .reset(reset),
        .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .req_ack(req_ack), .req_err(req_err), .req_tag(req_tag),
        .tx_type(tx_type), .tx_tag(tx_tag), .tx_addr(tx_addr), .tx_data(tx_data),
        .tx_start(tx_start), .tx_done(tx_done),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
        .tags_free(tags_free), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 user_clk = ~user_clk;

    // Requester side, one entry per port.
    logic        b_vld [NR];
    logic [2:0]  b_type[NR];
    logic [63:0] b_addr[NR];
    logic [31:0] b_data[NR];

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = b_vld[i];
            req_type[3*i +: 3]    = b_type[i];
            req_addr[64*i +: 64]  = b_addr[i];
            req_data[32*i +: 32]  = b_data[i];
        end
    end

    // Reference model state.
    int m_last;
    bit m_tag[NT];
    bit m_timeout;
    bit m_after_ack;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_posted(input logic [2:0] t);
        return (t == 3'd1) || (t == 3'd3);
    endfunction

    function automatic bit is_illegal(input logic [2:0] t);
        return t >= 3'd6;
    endfunction

    function automatic int free_count();
        int n = 0;
        for (int t = 0; t < NT; t++) if (!m_tag[t]) n++;
        return n;
    endfunction

    function automatic int lowest_free();
        for (int t = 0; t < NT; t++) if (!m_tag[t]) return t;
        return -1;
    endfunction

    function automatic int rand_alloc();
        int s = $urandom_range(0, NT - 1);
        for (int k = 0; k < NT; k++) if (m_tag[(s + k) % NT]) return (s + k) % NT;
        return -1;
    endfunction

    function automatic int pick();
        int i;
        for (int k = 1; k <= NR; k++) begin
            i = (m_last + k) % NR;
            if (b_vld[i] && (is_posted(b_type[i]) || is_illegal(b_type[i]) || free_count() > 0))
                return i;
        end
        return -1;
    endfunction

    task automatic new_req(input int i, input logic [2:0] t);
        b_vld[i]  = 1'b1;
        b_type[i] = t;
        b_addr[i] = {$urandom, $urandom};
        b_data[i] = $urandom;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cpl_valid = 1'b0;
        tx_done = 1'b0;
        for (int i = 0; i < NR; i++) b_vld[i] = 1'b0;
        repeat (3) begin
            @(negedge user_clk);
            check_eq("rst_no_ack", req_ack, 0);
        end
        reset = 1'b0;
        m_last = NR - 1;
        for (int t = 0; t < NT; t++) m_tag[t] = 1'b0;
        m_timeout = 1'b0;
        m_after_ack = 1'b0;
        @(negedge user_clk);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tags_free", tags_free, NT);
        check_eq("rst_timeout", timeout_err, 0);
        check_eq("rst_tx_tag", tx_tag, 0);
        check_eq("rst_tx_addr", tx_addr, 0);
        check_eq("rst_req_err", req_err, 0);
    endtask

    // One granted transaction. done_dly<0 withholds tx_done to force the watchdog.
    // cpl_mode: 0 none, 1 completion on the grant edge, 2 completion during START.
    task automatic step(input int done_dly, input int cpl_mode, input int cpl_t,
                        input bit spurious_done, output int winner);
        int w, exp_tag, n;
        bit seen, np;
        if (cpl_mode == 1 && m_after_ack) @(negedge user_clk);
        m_after_ack = 1'b0;
        w = pick();
        winner = w;
        if (w < 0) begin
            check_eq("no_eligible_requester", 0, 1);
            return;
        end
        m_last = w;
        np = !is_posted(b_type[w]) && !is_illegal(b_type[w]);
        exp_tag = np ? lowest_free() : 0;
        if (cpl_mode == 1) begin
            cpl_valid = 1'b1;
            cpl_tag = 8'(cpl_t);
            if (cpl_t < NT) m_tag[cpl_t] = 1'b0;
        end
        if (np) m_tag[exp_tag] = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge user_clk);
            cpl_valid = 1'b0;
            if (tx_start || req_ack != 0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("grant_seen", seen, 1);
        if (!seen) return;
        if (is_illegal(b_type[w])) begin
            check_eq("illegal_ack", req_ack, 4'b0001 << w);
            check_eq("illegal_err", req_err, 1);
            check_eq("illegal_no_start", tx_start, 0);
            check_eq("illegal_idle", busy, 0);
            b_vld[w] = 1'b0;
            m_after_ack = 1'b1;
            return;
        end
        check_eq("start_no_ack", req_ack, 0);
        check_eq("tx_type", tx_type, b_type[w]);
        check_eq("tx_addr", tx_addr, b_addr[w]);
        check_eq("tx_data", tx_data, b_data[w]);
        check_eq("tx_tag", tx_tag, exp_tag);
        check_eq("tags_free_grant", tags_free, free_count());
        if (cpl_mode == 2) begin
            cpl_valid = 1'b1;
            cpl_tag = 8'(cpl_t);
            if (cpl_t < NT) m_tag[cpl_t] = 1'b0;
        end
        if (spurious_done) tx_done = 1'b1;
        @(negedge user_clk);
        cpl_valid = 1'b0;
        tx_done = 1'b0;
        check_eq("start_one_cycle", tx_start, 0);
        check_eq("wait_busy", busy, 1);
        check_eq("wait_no_ack", req_ack, 0);
        if (done_dly < 0) begin
            n = 1;
            while (req_ack == 0 && n < 40) begin
                @(negedge user_clk);
                n++;
            end
            if (np) m_tag[exp_tag] = 1'b0;
            m_timeout = 1'b1;
            check_eq("timeout_latency", n, TO + 1);
            check_eq("timeout_err_flag", req_err, 1);
        end else begin
            repeat (done_dly) @(negedge user_clk);
            tx_done = 1'b1;
            @(negedge user_clk);
            tx_done = 1'b0;
            check_eq("done_err", req_err, 0);
        end
        check_eq("done_ack", req_ack, 4'b0001 << w);
        check_eq("done_req_tag", req_tag, exp_tag);
        check_eq("done_tx_addr_held", tx_addr, b_addr[w]);
        check_eq("done_idle", busy, 0);
        check_eq("done_timeout_sticky", timeout_err, m_timeout);
        check_eq("done_tags_free", tags_free, free_count());
        b_vld[w] = 1'b0;
        m_after_ack = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int w, t, mode, cpl_t;
        bit ok;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NR; i++) begin
            b_vld[i] = 1'b0; b_type[i] = '0; b_addr[i] = '0; b_data[i] = '0;
        end

        // Posted writes from all ports rotate and never touch the tag pool.
        apply_reset();
        for (int i = 0; i < NR; i++) new_req(i, 3'd1);
        for (int s = 0; s < 5; s++) begin
            step(2, 0, 0, 0, w);
            check_eq("rr_order", req_ack, 4'b0001 << exp_order[s]);
            check_eq("rr_posted_tag", tx_tag, 0);
            check_eq("rr_tags_free", tags_free, NT);
            if (w >= 0) new_req(w, 3'd1);
        end

        // Tag exhaustion and recovery on a single requester.
        apply_reset();
        for (int i = 0; i < NT; i++) begin
            new_req(2, 3'd2);
            step(0, 0, 0, 0, w);
            check_eq("exhaust_tag", req_tag, i);
        end
        new_req(2, 3'd2);
        ok = 1'b1;
        repeat (8) begin
            @(negedge user_clk);
            if (tx_start || busy) ok = 1'b0;
        end
        check_eq("exhaust_stall", ok, 1);
        check_eq("exhaust_tags_free", tags_free, 0);
        cpl_valid = 1'b1; cpl_tag = 8'd5; m_tag[5] = 1'b0;
        @(negedge user_clk);
        cpl_valid = 1'b0;
        step(1, 0, 0, 0, w);
        check_eq("exhaust_reuse_tag5", req_tag, 5);

        // Free of tag 7 on the same edge tag 8 is allocated.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            new_req(0, 3'd0);
            step(0, 0, 0, 0, w);
        end
        new_req(0, 3'd0);
        step(1, 1, 7, 0, w);
        check_eq("same_cycle_tag8", req_tag, 8);
        check_eq("same_cycle_net", tags_free, NT - 8);
        new_req(0, 3'd0);
        step(1, 0, 0, 0, w);
        check_eq("same_cycle_next_tag7", req_tag, 7);

        // Illegal type.
        apply_reset();
        new_req(1, 3'd6);
        step(0, 0, 0, 0, w);
        check_eq("illegal_port1_ack", req_ack, 4'b0010);
        ok = 1'b1;
        repeat (4) begin
            @(negedge user_clk);
            if (tx_start) ok = 1'b0;
        end
        check_eq("illegal_never_start", ok, 1);

        // Watchdog expiry frees the tag and is sticky.
        apply_reset();
        new_req(0, 3'd0);
        step(-1, 0, 0, 0, w);
        check_eq("timeout_tags_free", tags_free, NT);
        new_req(1, 3'd1);
        step(0, 0, 0, 0, w);
        check_eq("timeout_still_set", timeout_err, 1);

        // Reset during WAIT abandons the IORD.
        apply_reset();
        new_req(3, 3'd4);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge user_clk);
            if (tx_start) ok = 1'b1;
        end
        check_eq("iord_started", ok, 1);
        repeat (2) @(negedge user_clk);
        check_eq("iord_in_wait", busy, 1);
        apply_reset();
        new_req(0, 3'd0);
        step(0, 0, 0, 0, w);
        check_eq("after_reset_tag0", req_tag, 0);

        // Randomized traffic.
        apply_reset();
        for (int it = 0; it < 200; it++) begin
            for (int i = 0; i < NR; i++)
                if (!b_vld[i] && $urandom_range(0, 1) == 1) new_req(i, 3'($urandom_range(0, 7)));
            ok = 1'b0;
            for (int i = 0; i < NR; i++) if (b_vld[i]) ok = 1'b1;
            if (!ok) new_req($urandom_range(0, NR - 1), 3'($urandom_range(0, 7)));
            if (pick() < 0) begin
                t = rand_alloc();
                cpl_valid = 1'b1; cpl_tag = 8'(t); m_tag[t] = 1'b0;
                @(negedge user_clk);
                cpl_valid = 1'b0;
                m_after_ack = 1'b0;
            end
            mode = $urandom_range(0, 2);
            cpl_t = ($urandom_range(0, 1) == 1) ? rand_alloc() : $urandom_range(0, 40);
            if (cpl_t < 0) cpl_t = $urandom_range(0, 40);
            step($urandom_range(0, 6), mode, cpl_t, 1'($urandom_range(0, 1)), w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
